// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among 4 byte producers.
// Latency: tx_send is registered the cycle after a request is seen in IDLE; ack pulses the cycle after tx_busy falls.
// Backpressure: requesters hold req until ack; no grant while tx_busy is high or in the ack cycle itself.
// Optional: define UART_TX_ARB_TIMEOUT_EN to abort with ack+err when tx_busy never rises after tx_send.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_din,
   input  logic [NUM_REQ-1:0]   req_odd,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 err,
   output logic                 tx_send,
   output logic                 tx_odd,
   output logic [7:0]           tx_din,
   input  logic                 tx_busy
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t     state;
   logic [1:0] ptr;       // first requester to consider on the next arbitration
   logic [1:0] owner;     // index of the current grant holder
   logic       pick_vld;
   logic [1:0] pick;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;  // cycles spent in SEND without seeing tx_busy
`else
   // The timeout length only matters when the busy watchdog is built in.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (BUSY_TIMEOUT > 0);
   assign err = 1'b0;
`endif

   // Round-robin pick: scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick     = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[ptr + 2'(i)]) begin
            pick_vld = 1'b1;
            pick     = ptr + 2'(i);
         end
      end
   end

   // Grant / send / wait-for-frame / ack sequencer with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         owner   <= '0;
         ack     <= '0;
         gnt     <= '0;
         tx_send <= 1'b0;
         tx_odd  <= 1'b0;
         tx_din  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         cnt     <= '0;
         err     <= 1'b0;
`endif
      end else begin
         ack <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // A transmitter still busy from elsewhere blocks the grant.
               if (pick_vld && !tx_busy) begin
                  owner   <= pick;
                  gnt     <= NUM_REQ'(1) << pick;
                  tx_din  <= req_din[{pick, 3'b000} +: 8];
                  tx_odd  <= req_odd[pick];
                  tx_send <= 1'b1;
                  state   <= SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  cnt     <= '0;
`endif
               end
            end
            SEND: begin
               if (tx_busy) begin
                  tx_send <= 1'b0;
                  state   <= WAIT;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                  // Transmitter never picked up the byte: give up and report it.
                  tx_send <= 1'b0;
                  ack     <= gnt;
                  err     <= 1'b1;
                  gnt     <= '0;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            WAIT: begin
               // Falling busy marks the end of the stop bit.
               if (!tx_busy) begin
                  ack   <= gnt;
                  gnt   <= '0;
                  state <= DONE;
               end
            end
            DONE: begin
               // The ack is visible in this cycle; the next grant starts after it.
               ptr   <= owner + 2'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed test of the 4-way UART transmitter arbiter.
// A short-bit-time transmitter stand-in answers the send/busy handshake and records frames.
// A transaction-level model predicts all arbiter outputs and is compared every cycle.
module tb_uart_tx_arbiter;

   localparam int TIMEOUT = 16;
   localparam int BIT_CYC = 4;
   localparam int FRAME_CYC = 11 * BIT_CYC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_din;
   logic [3:0]  req_odd;
   logic [3:0]  ack;
   logic [3:0]  gnt;
   logic        err;
   logic        tx_send;
   logic        tx_odd;
   logic [7:0]  tx_din;
   logic        tx_busy = 1'b0;

   int passed = 0;
   int total  = 0;

   logic cmp_en = 1'b0;
   logic tx_stuck = 1'b0;
   logic tx_force_busy = 1'b0;
   int   rereq_left [4];

   logic [10:0] frames [$];
   bit          stable_q [$];

   logic [3:0]  simul_ack   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [10:0] simul_frame [4] = '{11'h5FE, 11'h600, 11'h41E, 11'h7E0};
   logic [3:0]  fair_ack    [3] = '{4'b1000, 4'b0001, 4'b1000};

   uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .req_din (req_din),
      .req_odd (req_odd),
      .ack     (ack),
      .gnt     (gnt),
      .err     (err),
      .tx_send (tx_send),
      .tx_odd  (tx_odd),
      .tx_din  (tx_din),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Serial frame as {stop, parity, data, start}; odd=1 selects odd parity.
   function automatic logic [10:0] frame_of(input logic [7:0] d, input logic o);
      return {1'b1, (o ? ~^d : ^d), d, 1'b0};
   endfunction

   // Transmitter stand-in: accepts tx_send, stays busy for one frame, records what it sent.
   logic [7:0] tx_lat_din;
   logic       tx_lat_odd;
   int         tx_left = 0;
   bit         tx_stable = 1'b1;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         tx_busy = 1'b0;
         tx_left = 0;
      end else if (tx_force_busy) begin
         tx_busy = 1'b1;
      end else if (tx_left > 0) begin
         if (tx_din !== tx_lat_din || tx_odd !== tx_lat_odd) tx_stable = 1'b0;
         tx_left--;
         if (tx_left == 0) begin
            tx_busy = 1'b0;
            frames.push_back(frame_of(tx_lat_din, tx_lat_odd));
            stable_q.push_back(tx_stable);
         end
      end else if (tx_send && !tx_stuck) begin
         tx_busy    = 1'b1;
         tx_left    = FRAME_CYC;
         tx_lat_din = tx_din;
         tx_lat_odd = tx_odd;
         tx_stable  = 1'b1;
      end else begin
         tx_busy = 1'b0;
      end
   end

   // Transaction-level model: who owns the transmitter, whether busy was seen, and the ack gap.
   int         m_owner = -1;
   int         m_ptr = 0;
   int         m_wait = 0;
   bit         m_seen = 1'b0;
   bit         m_gap = 1'b0;
   bit         m_fin = 1'b0;
   bit         m_abort = 1'b0;
   logic [3:0] e_gnt = '0, e_ack = '0;
   logic       e_err = 1'b0, e_send = 1'b0, e_odd = 1'b0;
   logic [7:0] e_din = '0;
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_gap = 1'b0; m_seen = 1'b0;
         e_gnt = '0; e_ack = '0; e_err = 1'b0; e_send = 1'b0; e_odd = 1'b0; e_din = '0;
      end else begin
         e_ack = '0;
         e_err = 1'b0;
         m_fin = 1'b0;
         m_abort = 1'b0;
         if (m_gap) begin
            m_gap = 1'b0;
         end else if (m_owner < 0) begin
            if (req != 4'b0000 && !tx_busy) begin
               for (int i = 0; i < 4; i++)
                  if (m_owner < 0 && req[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
               e_gnt  = 4'b0001 << m_owner;
               e_din  = req_din[8*m_owner +: 8];
               e_odd  = req_odd[m_owner];
               e_send = 1'b1;
               m_seen = 1'b0;
               m_wait = 0;
            end
         end else if (!m_seen) begin
            if (tx_busy) begin
               m_seen = 1'b1;
               e_send = 1'b0;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else begin
               m_wait++;
               if (m_wait == TIMEOUT) begin
                  m_fin = 1'b1;
                  m_abort = 1'b1;
               end
            end
`endif
         end else if (!tx_busy) begin
            m_fin = 1'b1;
         end
         if (m_fin) begin
            e_ack   = 4'b0001 << m_owner;
            e_err   = m_abort;
            e_gnt   = '0;
            e_send  = 1'b0;
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_gap   = 1'b1;
         end
      end
   end

   // Every-cycle comparison of all arbiter outputs against the model.
   initial forever begin
      @(negedge clk);
      if (cmp_en)
         check("cycle_outputs", {13'd0, gnt, ack, err, tx_send, tx_odd, tx_din},
               {13'd0, e_gnt, e_ack, e_err, e_send, e_odd, e_din});
   end

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (ack[k]) begin
            if (rereq_left[k] > 0) rereq_left[k]--;
            else req[k] = 1'b0;
         end
      end
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      req   = '0;
      #1;
      check(nm, {13'd0, gnt, ack, err, tx_send, tx_odd, tx_din}, 32'd0);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_ack(output logic [3:0] a);
      a = '0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (ack != 4'b0000) begin
            a = ack;
            return;
         end
      end
   endtask

   task automatic check_frame(input string nm, input logic [10:0] want);
      logic [10:0] got;
      bit          st;
      got = '0;
      st  = 1'b0;
      if (frames.size() > 0) got = frames.pop_front();
      if (stable_q.size() > 0) st = stable_q.pop_front();
      check(nm, {21'd0, got}, {21'd0, want});
      check({nm, "_din_stable"}, {31'd0, st}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] a;
      int         gap;
      int         n;
      bit         seen;
      rst_n = 1'b1; req = '0; req_din = '0; req_odd = '0;
      for (int k = 0; k < 4; k++) rereq_left[k] = 0;

      // Single request from requester 1.
      do_reset("reset_state");
      req_din[15:8] = 8'h37; req_odd[1] = 1'b0; req = 4'b0010;
      tick();
      check("single_send_gnt", {27'd0, tx_send, gnt}, {27'd0, 5'b1_0010});
      wait_ack(a);
      check("single_ack", {28'd0, a}, 32'h2);
      check_frame("single_frame", 11'h66E);

      // All four at once from ptr=0.
      do_reset("reset_state2");
      req_din = {8'hf0, 8'h0f, 8'h00, 8'hff}; req_odd = 4'b1010; req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(a);
         check("simul_ack", {28'd0, a}, {28'd0, simul_ack[k]});
         check("simul_ack_onehot", $countones(a), 1);
         check_frame("simul_frame", simul_frame[k]);
      end

      // Move ptr to 3, then 3 and 0 request with 3 re-requesting immediately.
      req_din[23:16] = 8'h81; req_odd[2] = 1'b1; req = 4'b0100;
      wait_ack(a);
      check("wrap_pre_ack", {28'd0, a}, 32'h4);
      check_frame("wrap_pre_frame", frame_of(8'h81, 1'b1));
      req_din[31:24] = 8'hc3; req_odd[3] = 1'b0; req_din[7:0] = 8'h18; req_odd[0] = 1'b1;
      rereq_left[3] = 1;
      req = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         wait_ack(a);
         check("fair_ack", {28'd0, a}, {28'd0, fair_ack[k]});
         check_frame("fair_frame", (k == 1) ? frame_of(8'h18, 1'b1) : frame_of(8'hc3, 1'b0));
      end

      // Requester 1 holds req for three frames.
      req_din[15:8] = 8'h5c; req_odd[1] = 1'b1; rereq_left[1] = 2; req = 4'b0010;
      for (int f = 0; f < 3; f++) begin
         wait_ack(a);
         check("b2b_ack", {28'd0, a}, 32'h2);
         check_frame("b2b_frame", frame_of(8'h5c, 1'b1));
         if (f < 2) begin
            gap = 0;
            do begin
               tick();
               gap++;
            end while (!tx_send && gap < 20);
            check("b2b_gap", gap, 2);
         end
      end

      // Reset halfway through the data bits of 8'haa.
      req_din[23:16] = 8'haa; req_odd[2] = 1'b0; req = 4'b0100;
      tick();
      repeat (16) tick();
      do_reset("midframe_reset");
      req_din[15:8] = 8'h55; req_odd[1] = 1'b1; req_din[31:24] = 8'h3c; req_odd[3] = 1'b0;
      req = 4'b1010;
      tick();
      check("post_reset_gnt", {28'd0, gnt}, 32'h2);
      wait_ack(a);
      check("post_reset_ack", {28'd0, a}, 32'h2);
      check_frame("post_reset_frame", 11'h6AA);
      wait_ack(a);
      check("post_reset_ack3", {28'd0, a}, 32'h8);
      check_frame("post_reset_frame3", frame_of(8'h3c, 1'b0));

      // Transmitter busy while idle holds off the grant.
      tx_force_busy = 1'b1;
      tick(); tick();
      req_din[7:0] = 8'h96; req_odd[0] = 1'b0; req = 4'b0001;
      repeat (5) tick();
      check("busy_idle_no_gnt", {27'd0, tx_send, gnt}, 32'd0);
      tx_force_busy = 1'b0;
      wait_ack(a);
      check("busy_idle_ack", {28'd0, a}, 32'h1);
      check_frame("busy_idle_frame", frame_of(8'h96, 1'b0));

      // Transmitter never raises busy.
      do_reset("stuck_reset");
      tx_stuck = 1'b1;
      req_din[23:16] = 8'h5a; req_odd[2] = 1'b0; req = 4'b0100;
      tick();
      check("stuck_send_rise", {31'd0, tx_send}, 32'd1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!tx_send) break;
         n++;
      end
      check("stuck_send_cycles", n, TIMEOUT);
      check("stuck_ack_err", {27'd0, ack, err}, {27'd0, 5'b0100_1});
`else
      n = 0;
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (ack != 4'b0000) seen = 1'b1;
         if (tx_send) n++;
      end
      check("stuck_send_held", n, 40);
      check("stuck_no_ack", {31'd0, seen}, 32'd0);
`endif
      tx_stuck = 1'b0;
      do_reset("final_reset");
      repeat (3) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
